tlb_maint_ctrl: RTL and testbench

- TLB maintenance sequencer sitting directly upstream of the mmu TLB array; it is the only source of `tlb_write_req` into that array.
- Executes TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB issued from the CSR/privileged-op pipeline.
- Multi-entry ops (TLBSRCH, INVTLB) walk all entries through the mmu's one-cycle registered read port, one index per cycle.
- Results go back to the CSR unit: search hit/index, read entry, invalid-op flag.

---
 rtl/tlb_maint_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_tlb_maint_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: sole writer of the mmu TLB array, walking its
// one-cycle registered read port for TLBSRCH/INVTLB and handling TLBRD/TLBWR/TLBFILL.
package tlb_maint_pkg;
    localparam int TLB_NUM = 64;

    typedef struct packed {
        logic [18:0] vppn;
        logic        huge_page;
        logic        g;
        logic [9:0]  asid;
        logic        e;
    } tlb_key_t;

    typedef struct packed {
        tlb_key_t    key;
        logic [31:0] data;
    } tlb_entry_t;

    // The strobe vector is sized by the package, so TLB_ENTRY_NUM must not exceed TLB_NUM.
    typedef struct packed {
        logic [TLB_NUM-1:0] we;
        tlb_entry_t         entry;
    } tlb_write_req_t;
endpackage

module tlb_maint_ctrl
    import tlb_maint_pkg::*;
#(
    parameter int TLB_ENTRY_NUM = TLB_NUM,
    parameter int IDX_W         = $clog2(TLB_ENTRY_NUM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [2:0]       op_i,
    input  logic [4:0]       inv_op_i,
    input  logic [9:0]       inv_asid_i,
    input  logic [31:0]      inv_va_i,
    input  logic [IDX_W-1:0] csr_index_i,
    input  logic             csr_ne_i,
    input  logic [18:0]      csr_vppn_i,
    input  logic [9:0]       csr_asid_i,
    input  tlb_entry_t       csr_entry_i,
    output logic [IDX_W-1:0] tlb_rd_idx_o,
    input  tlb_entry_t       tlb_rd_entry_i,
    output tlb_write_req_t   tlb_write_req_o,
    output logic             done_o,
    output logic             srch_hit_o,
    output logic [IDX_W-1:0] srch_idx_o,
    output tlb_entry_t       rd_entry_o,
    output logic             inv_err_o
);
    localparam logic [2:0]       OP_SRCH  = 3'd0;
    localparam logic [2:0]       OP_RD    = 3'd1;
    localparam logic [2:0]       OP_WR    = 3'd2;
    localparam logic [2:0]       OP_FILL  = 3'd3;
    localparam logic [2:0]       OP_INV   = 3'd4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRY_NUM - 1);

    typedef enum logic [1:0] {IDLE, WALK, DRAIN, FIN} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic [4:0]       inv_op_q;
    logic [9:0]       asid_q;
    logic [18:0]      vpn_q;
    logic [IDX_W-1:0] fill_cnt;
    logic [IDX_W-1:0] cmp_idx;
    logic [IDX_W-1:0] found_idx;
    logic             cmp_valid;
    logic             found;
    logic             entry_hit;
    logic             illegal_op;
    tlb_key_t         rd_key;
    logic             unused_va_low;

    // Only the page number of the INVTLB va takes part in matching.
    assign unused_va_low = ^inv_va_i[12:0];
    assign op_ready_o    = (state == IDLE);
    assign rd_key        = tlb_rd_entry_i.key;
    assign illegal_op    = (op_i > OP_INV) || (op_i == OP_INV && inv_op_i > 5'd6);

    function automatic logic va_match(input tlb_key_t k, input logic [18:0] vpn);
        return k.huge_page ? (vpn[18:9] == k.vppn[18:9]) : (vpn == k.vppn);
    endfunction

    always_comb begin
        entry_hit = 1'b0;
        if (op_q == OP_SRCH) begin
            entry_hit = rd_key.e && va_match(rd_key, vpn_q) && (rd_key.g || rd_key.asid == asid_q);
        end else begin
            case (inv_op_q)
                5'd0, 5'd1: entry_hit = 1'b1;
                5'd2:       entry_hit = rd_key.g;
                5'd3:       entry_hit = !rd_key.g;
                5'd4:       entry_hit = !rd_key.g && rd_key.asid == asid_q;
                5'd5:       entry_hit = !rd_key.g && rd_key.asid == asid_q && va_match(rd_key, vpn_q);
                5'd6:       entry_hit = (rd_key.g || rd_key.asid == asid_q) && va_match(rd_key, vpn_q);
                default:    entry_hit = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fill_cnt <= '0;
        else     fill_cnt <= (fill_cnt == LAST_IDX) ? '0 : fill_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            op_q            <= '0;
            inv_op_q        <= '0;
            asid_q          <= '0;
            vpn_q           <= '0;
            cmp_idx         <= '0;
            found_idx       <= '0;
            cmp_valid       <= 1'b0;
            found           <= 1'b0;
            tlb_rd_idx_o    <= '0;
            tlb_write_req_o <= '0;
            done_o          <= 1'b0;
            srch_hit_o      <= 1'b0;
            srch_idx_o      <= '0;
            rd_entry_o      <= '0;
            inv_err_o       <= 1'b0;
        end else begin
            done_o             <= 1'b0;
            inv_err_o          <= 1'b0;
            tlb_write_req_o.we <= '0;
            case (state)
                IDLE: if (op_valid_i) begin
                    op_q      <= op_i;
                    inv_op_q  <= inv_op_i;
                    found     <= 1'b0;
                    found_idx <= '0;
                    if (illegal_op) begin
                        done_o    <= 1'b1;
                        inv_err_o <= 1'b1;
                        state     <= FIN;
                    end else if (op_i == OP_WR || op_i == OP_FILL) begin
                        tlb_write_req_o.we[(op_i == OP_FILL) ? fill_cnt : csr_index_i] <= 1'b1;
                        tlb_write_req_o.entry       <= csr_entry_i;
                        tlb_write_req_o.entry.key.e <= csr_entry_i.key.e & ~csr_ne_i;
                        done_o <= 1'b1;
                        state  <= FIN;
                    end else begin
                        tlb_rd_idx_o <= (op_i == OP_RD) ? csr_index_i : '0;
                        asid_q       <= (op_i == OP_SRCH) ? csr_asid_i : inv_asid_i;
                        vpn_q        <= (op_i == OP_SRCH) ? csr_vppn_i : inv_va_i[31:13];
                        state        <= WALK;
                    end
                end
                WALK: begin
                    if (op_q == OP_RD) begin
                        state <= DRAIN;
                    end else begin
                        cmp_valid <= 1'b1;
                        cmp_idx   <= tlb_rd_idx_o;
                        if (tlb_rd_idx_o == LAST_IDX) state <= DRAIN;
                        else                          tlb_rd_idx_o <= tlb_rd_idx_o + 1'b1;
                    end
                end
                DRAIN: begin
                    // The last walked entry is still being compared here, so it folds into the result.
                    cmp_valid <= 1'b0;
                    done_o    <= 1'b1;
                    state     <= FIN;
                    if (op_q == OP_RD) rd_entry_o <= tlb_rd_entry_i;
                    if (op_q == OP_SRCH) begin
                        srch_hit_o <= found | entry_hit;
                        srch_idx_o <= found ? found_idx : (entry_hit ? cmp_idx : '0);
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (cmp_valid && entry_hit) begin
                if (op_q == OP_SRCH && !found) begin
                    found     <= 1'b1;
                    found_idx <= cmp_idx;
                end
                if (op_q == OP_INV) begin
                    tlb_write_req_o.we[cmp_idx]  <= 1'b1;
                    tlb_write_req_o.entry        <= tlb_rd_entry_i;
                    tlb_write_req_o.entry.key.e  <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Scoreboard bench for tlb_maint_ctrl: the bench models the mmu array and predicts
// every write strobe and completion from the TLB maintenance rules.
module tb_tlb_maint_ctrl;
    import tlb_maint_pkg::*;

    localparam int N  = 64;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           op_valid;
    logic           op_ready;
    logic [2:0]     op;
    logic [4:0]     inv_op;
    logic [9:0]     inv_asid;
    logic [31:0]    inv_va;
    logic [IW-1:0]  csr_index;
    logic           csr_ne;
    logic [18:0]    csr_vppn;
    logic [9:0]     csr_asid;
    tlb_entry_t     csr_entry;
    logic [IW-1:0]  rd_idx;
    tlb_entry_t     rd_q;
    tlb_write_req_t wreq;
    logic           done;
    logic           srch_hit;
    logic [IW-1:0]  srch_idx;
    tlb_entry_t     rd_entry_out;
    logic           inv_err;

    typedef struct {
        int         cyc;
        bit         has_wr;
        int         wr_idx;
        tlb_entry_t wr_entry;
        bit         has_done;
        bit         inv_err;
        bit         hit;
        int         sidx;
        tlb_entry_t rd;
    } exp_t;

    exp_t       sb[$];
    tlb_entry_t mmu_mem[N];
    tlb_entry_t ref_mem[N];
    bit         preload = 1'b1;
    bit         m_hit = 1'b0;
    int         m_idx = 0;
    tlb_entry_t m_rd = '0;
    int         cyc = 0;
    int         rst_rel_cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tlb_maint_ctrl #(.TLB_ENTRY_NUM(N)) dut (
        .clk(clk), .rst(rst), .op_valid_i(op_valid), .op_ready_o(op_ready), .op_i(op),
        .inv_op_i(inv_op), .inv_asid_i(inv_asid), .inv_va_i(inv_va), .csr_index_i(csr_index),
        .csr_ne_i(csr_ne), .csr_vppn_i(csr_vppn), .csr_asid_i(csr_asid), .csr_entry_i(csr_entry),
        .tlb_rd_idx_o(rd_idx), .tlb_rd_entry_i(rd_q), .tlb_write_req_o(wreq), .done_o(done),
        .srch_hit_o(srch_hit), .srch_idx_o(srch_idx), .rd_entry_o(rd_entry_out), .inv_err_o(inv_err)
    );

    // The mmu array: one-cycle registered read, writes land on the clock edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < N; k++) mmu_mem[k] <= ref_mem[k];
        end else begin
            for (int k = 0; k < N; k++) if (wreq.we[k]) mmu_mem[k] <= wreq.entry;
        end
        rd_q <= mmu_mem[rd_idx];
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit va_hit(input tlb_entry_t ent, input logic [18:0] vpn);
        if (ent.key.huge_page) return ent.key.vppn[18:9] == vpn[18:9];
        return ent.key.vppn == vpn;
    endfunction

    function automatic bit inv_hit(input tlb_entry_t ent, input int code, input logic [9:0] a, input logic [18:0] vpn);
        bit own = !ent.key.g && ent.key.asid == a;
        case (code)
            0, 1:    return 1'b1;
            2:       return ent.key.g;
            3:       return !ent.key.g;
            4:       return own;
            5:       return own && va_hit(ent, vpn);
            6:       return (ent.key.g || ent.key.asid == a) && va_hit(ent, vpn);
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t make_item(input int c);
        exp_t x;
        x.cyc = c; x.has_wr = 0; x.wr_idx = 0; x.wr_entry = '0; x.has_done = 0;
        x.inv_err = 0; x.hit = m_hit; x.sidx = m_idx; x.rd = m_rd;
        return x;
    endfunction

    function automatic logic [18:0] rand_vppn();
        case ($urandom_range(0, 3))
            0:       return 19'h12345;
            1:       return 19'h12345 ^ 19'($urandom_range(1, 511));
            2:       return 19'h00abc;
            default: return 19'($urandom);
        endcase
    endfunction

    function automatic tlb_entry_t rand_entry();
        tlb_entry_t r;
        r.key.vppn      = rand_vppn();
        r.key.huge_page = ($urandom_range(0, 3) == 0);
        r.key.g         = 1'($urandom_range(0, 1));
        r.key.asid      = $urandom_range(0, 1) ? 10'd7 : 10'($urandom_range(0, 3));
        r.key.e         = ($urandom_range(0, 3) != 0);
        r.data          = $urandom;
        return r;
    endfunction

    function automatic tlb_entry_t mk_entry(input logic [18:0] v, input bit g, input logic [9:0] a, input logic [31:0] d);
        tlb_entry_t r;
        r.key.vppn = v; r.key.huge_page = 1'b0; r.key.g = g; r.key.asid = a; r.key.e = 1'b1; r.data = d;
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [63:0] exp_we;
        if (!rst && (wreq.we != '0 || done)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: cycle %0d we=%h done=%b, expected no activity", cyc, wreq.we, done);
            end else begin
                e = sb.pop_front();
                check_output("event_cycle", 64'(cyc), 64'(e.cyc));
                exp_we = e.has_wr ? (64'd1 << e.wr_idx) : 64'd0;
                check_output("write_strobe", wreq.we, exp_we);
                if (e.has_wr) begin
                    check_output("write_entry", wreq.entry, e.wr_entry);
                    ref_mem[e.wr_idx] = e.wr_entry;
                end
                check_output("done", 64'(done), 64'(e.has_done));
                if (e.has_done) begin
                    check_output("inv_err", 64'(inv_err), 64'(e.inv_err));
                    check_output("srch_hit", 64'(srch_hit), 64'(e.hit));
                    check_output("srch_idx", 64'(srch_idx), 64'(e.sidx));
                    check_output("rd_entry", rd_entry_out, e.rd);
                end
            end
        end
    end

    task automatic apply_stimulus(input int op_code, input int inv_code, input logic [9:0] ia,
                                  input logic [31:0] iva, input int idx, input bit ne,
                                  input logic [18:0] vppn, input logic [9:0] asid,
                                  input tlb_entry_t ent, input int abort_at);
        int         t;
        int         n;
        exp_t       e;
        tlb_entry_t w;
        @(negedge clk);
        n = 0;
        while (!op_ready && n < 300) begin @(negedge clk); n++; end
        if (!op_ready) begin
            checks++; errors++;
            $display("[TB] FAIL ready_timeout: op_ready=0, expected 1 within 300 cycles");
            return;
        end
        op_valid = 1'b1; op = 3'(op_code); inv_op = 5'(inv_code); inv_asid = ia; inv_va = iva;
        csr_index = IW'(idx); csr_ne = ne; csr_vppn = vppn; csr_asid = asid; csr_entry = ent;
        t = cyc;
        if (op_code > 4 || (op_code == 4 && inv_code > 6)) begin
            e = make_item(t + 1); e.has_done = 1; e.inv_err = 1; sb.push_back(e);
        end else if (op_code == 0) begin
            m_hit = 0; m_idx = 0;
            for (int k = N - 1; k >= 0; k--)
                if (ref_mem[k].key.e && va_hit(ref_mem[k], vppn) && (ref_mem[k].key.g || ref_mem[k].key.asid == asid)) begin
                    m_hit = 1; m_idx = k;
                end
            e = make_item(t + N + 2); e.has_done = 1; sb.push_back(e);
        end else if (op_code == 1) begin
            m_rd = ref_mem[idx];
            e = make_item(t + 3); e.has_done = 1; sb.push_back(e);
        end else if (op_code == 2 || op_code == 3) begin
            w = ent;
            if (ne) w.key.e = 1'b0;
            e = make_item(t + 1); e.has_wr = 1; e.wr_entry = w; e.has_done = 1;
            e.wr_idx = (op_code == 2) ? idx : (t - rst_rel_cyc) % N;
            sb.push_back(e);
        end else begin
            for (int k = 0; k < N; k++)
                if (inv_hit(ref_mem[k], inv_code, ia, iva[31:13])) begin
                    w = ref_mem[k]; w.key.e = 1'b0;
                    e = make_item(t + 3 + k); e.has_wr = 1; e.wr_idx = k; e.wr_entry = w;
                    sb.push_back(e);
                end
            if (sb.size() > 0 && sb[$].cyc == t + N + 2) begin
                e = sb.pop_back(); e.has_done = 1; sb.push_back(e);
            end else begin
                e = make_item(t + N + 2); e.has_done = 1; sb.push_back(e);
            end
        end
        @(negedge clk);
        op_valid = 1'b0; op = 3'($urandom); inv_op = 5'($urandom); inv_asid = 10'($urandom);
        inv_va = $urandom; csr_index = IW'($urandom); csr_ne = 1'($urandom);
        csr_vppn = 19'($urandom); csr_asid = 10'($urandom); csr_entry = {$urandom, $urandom};
        if (abort_at > 0) begin
            do begin @(posedge clk); #1; end while (cyc < t + abort_at);
            rst = 1'b1;
            sb.delete();
            m_hit = 0; m_idx = 0; m_rd = '0;
            @(negedge clk);
            check_output("abort_rst_no_done", 64'(done), 64'd0);
            check_output("abort_rst_no_write", wreq.we, 64'd0);
            @(negedge clk);
            rst = 1'b0;
            rst_rel_cyc = cyc;
            repeat (3) @(negedge clk);
            check_output("abort_ready_after", 64'(op_ready), 64'd1);
        end else begin
            n = 0;
            while (sb.size() != 0 && n < N + 20) begin @(negedge clk); n++; end
            if (sb.size() != 0) begin
                checks++; errors++;
                $display("[TB] FAIL op_done_timeout: %0d events pending, expected 0", sb.size());
                sb.delete();
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tlb_entry_t e9;
        int         r;
        op_valid = 0; op = 0; inv_op = 0; inv_asid = 0; inv_va = 0; csr_index = 0;
        csr_ne = 0; csr_vppn = 0; csr_asid = 0; csr_entry = '0;
        // Background contents never collide with the directed vppn 0x12345 or asid 7.
        for (int k = 0; k < N; k++) begin
            ref_mem[k].key.vppn      = 19'($urandom_range(0, 16'hffff));
            ref_mem[k].key.huge_page = 1'($urandom_range(0, 1));
            ref_mem[k].key.g         = 1'($urandom_range(0, 1));
            ref_mem[k].key.asid      = 10'($urandom_range(0, 3));
            ref_mem[k].key.e         = 1'($urandom_range(0, 1));
            ref_mem[k].data          = $urandom;
        end
        repeat (3) @(negedge clk);
        preload = 1'b0;
        check_output("reset_op_ready", 64'(op_ready), 64'd1);
        check_output("reset_done", 64'(done), 64'd0);
        check_output("reset_we", wreq.we, 64'd0);
        check_output("reset_srch_hit", 64'(srch_hit), 64'd0);
        check_output("reset_srch_idx", 64'(srch_idx), 64'd0);
        check_output("reset_rd_entry", rd_entry_out, 64'd0);
        check_output("reset_inv_err", 64'(inv_err), 64'd0);
        check_output("reset_rd_idx", 64'(rd_idx), 64'd0);
        rst = 1'b0;
        rst_rel_cyc = cyc;
        repeat (10) begin
            @(negedge clk);
            check_output("idle_no_write", wreq.we, 64'd0);
        end

        apply_stimulus(2, 0, 0, 0, 5, 0, 0, 0, mk_entry(19'h00111, 0, 10'd1, 32'haaaa_0005), 0);
        apply_stimulus(2, 0, 0, 0, 5, 1, 0, 0, mk_entry(19'h00111, 0, 10'd1, 32'hbbbb_0005), 0);
        apply_stimulus(2, 0, 0, 0, 3, 0, 0, 0, mk_entry(19'h12345, 0, 10'd7, 32'h0000_0003), 0);
        apply_stimulus(2, 0, 0, 0, 9, 0, 0, 0, mk_entry(19'h12345, 0, 10'd7, 32'h0000_0009), 0);
        apply_stimulus(2, 0, 0, 0, 20, 0, 0, 0, mk_entry(19'h12345, 1, 10'd2, 32'h0000_0014), 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 19'h12345, 10'd7, '0, 0);
        check_output("directed_srch_hit", 64'(srch_hit), 64'd1);
        check_output("directed_srch_idx", 64'(srch_idx), 64'd3);
        apply_stimulus(4, 4, 10'd7, 32'h0, 0, 0, 0, 0, '0, 0);
        apply_stimulus(4, 9, 10'd7, 32'h0, 0, 0, 0, 0, '0, 0);
        apply_stimulus(1, 0, 0, 0, 9, 0, 0, 0, '0, 0);
        e9 = mk_entry(19'h12345, 0, 10'd7, 32'h0000_0009);
        e9.key.e = 1'b0;
        check_output("directed_rd_entry9", rd_entry_out, e9);
        apply_stimulus(1, 0, 0, 0, 20, 0, 0, 0, '0, 0);
        check_output("directed_entry20_kept", rd_entry_out, mk_entry(19'h12345, 1, 10'd2, 32'h0000_0014));

        apply_stimulus(4, 0, 10'd0, 32'h0, 0, 0, 0, 0, '0, 30);
        apply_stimulus(3, 0, 0, 0, 0, 0, 0, 0, rand_entry(), 0);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 19);
            apply_stimulus(r < 4 ? 0 : r < 7 ? 1 : r < 11 ? 2 : r < 14 ? 3 : r < 18 ? 4 : $urandom_range(5, 7),
                           $urandom_range(0, 8),
                           $urandom_range(0, 1) ? 10'd7 : 10'($urandom_range(0, 3)),
                           {rand_vppn(), 13'($urandom)},
                           $urandom_range(0, N - 1), 1'($urandom_range(0, 1)), rand_vppn(),
                           $urandom_range(0, 1) ? 10'd7 : 10'($urandom_range(0, 3)),
                           rand_entry(), 0);
        end

        repeat (5) @(negedge clk);
        check_output("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
